// File: rtl/gaplus_hvgen.sv
// gaplus_hvgen: video timing generator for a Gaplus-style raster.
//
// A free-running MCLK divider produces a one-cycle pixel enable. Horizontal
// and vertical counters advance on that enable. Blank, sync and frame-strobe
// outputs are registered, so every output changes on the same MCLK edge as
// PH/PV with no relative skew.
//
// Ports
//   MCLK     in   1  master clock, sole clock
//   RESET_N  in   1  asynchronous active-low reset
//   HOFS     in   4  signed horizontal sync shift (pixels), taken at frame start
//   VOFS     in   4  signed vertical sync shift (lines), taken at frame start
//   PCLK_EN  out  1  one-MCLK pixel enable (divider at CLKDIV-1)
//   PH       out  9  horizontal counter 0..HTOTAL-1
//   PV       out  9  vertical counter 0..VTOTAL-1
//   HBLK     out  1  horizontal blank (PH >= HVIS)
//   VBLK     out  1  vertical blank (PV >= VVIS)
//   HSYN     out  1  horizontal sync window, shifted by latched HOFS
//   VSYN     out  1  vertical sync window, shifted by latched VOFS
//   VB_STB   out  1  one-MCLK strobe, one cycle after VBLK rises
module gaplus_hvgen #(
    parameter int CLKDIV   = 8,
    parameter int HTOTAL   = 384,
    parameter int HVIS     = 288,
    parameter int VTOTAL   = 264,
    parameter int VVIS     = 224,
    parameter int HS_START = 320,
    parameter int HS_WIDTH = 32,
    parameter int VS_START = 240,
    parameter int VS_WIDTH = 3
) (
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    output logic       PCLK_EN,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYN,
    output logic       VSYN,
    output logic       VB_STB
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [8:0]    H_LAST   = 9'(HTOTAL - 1);
    localparam logic [8:0]    V_LAST   = 9'(VTOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pclk_en_q, pclk_en_d;
    logic [8:0]    ph_q, ph_d;
    logic [8:0]    pv_q, pv_d;
    logic [3:0]    h_q, h_d;
    logic [3:0]    v_q, v_d;
    logic          hblk_q, hblk_d;
    logic          vblk_q, vblk_d;
    logic          hsyn_q, hsyn_d;
    logic          vsyn_q, vsyn_d;
    logic          vblk_dly_q;
    logic          vb_stb_q, vb_stb_d;

    logic          h_wrap;
    logic          frame_wrap;
    logic [9:0]    hs_lo, hs_hi;
    logic [9:0]    vs_lo, vs_hi;

    always_comb begin
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // Registered so the enable is high exactly while the divider holds CLKDIV-1.
        pclk_en_d = (div_d == DIV_LAST);

        h_wrap     = pclk_en_q && (ph_q == H_LAST);
        frame_wrap = h_wrap && (pv_q == V_LAST);

        ph_d = ph_q;
        if (pclk_en_q) begin
            ph_d = h_wrap ? 9'd0 : ph_q + 9'd1;
        end
        pv_d = pv_q;
        if (h_wrap) begin
            pv_d = (pv_q == V_LAST) ? 9'd0 : pv_q + 9'd1;
        end

        // Offsets only take effect from the frame-start edge onwards.
        h_d = frame_wrap ? HOFS : h_q;
        v_d = frame_wrap ? VOFS : v_q;

        // Sign-extended offsets; one spare bit keeps the compare window honest.
        hs_lo = 10'(HS_START) + {{6{h_d[3]}}, h_d};
        hs_hi = hs_lo + 10'(HS_WIDTH - 1);
        vs_lo = 10'(VS_START) + {{6{v_d[3]}}, v_d};
        vs_hi = vs_lo + 10'(VS_WIDTH - 1);

        // Decoded from the next counter values so they switch with PH/PV.
        hblk_d = (ph_d >= 9'(HVIS));
        vblk_d = (pv_d >= 9'(VVIS));
        hsyn_d = ({1'b0, ph_d} >= hs_lo) && ({1'b0, ph_d} <= hs_hi);
        vsyn_d = ({1'b0, pv_d} >= vs_lo) && ({1'b0, pv_d} <= vs_hi);

        vb_stb_d = vblk_q && !vblk_dly_q;
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q      <= '0;
            pclk_en_q  <= 1'b0;
            ph_q       <= 9'd0;
            pv_q       <= 9'd0;
            h_q        <= 4'd0;
            v_q        <= 4'd0;
            hblk_q     <= 1'b0;
            vblk_q     <= 1'b0;
            hsyn_q     <= 1'b0;
            vsyn_q     <= 1'b0;
            vblk_dly_q <= 1'b0;
            vb_stb_q   <= 1'b0;
        end else begin
            div_q      <= div_d;
            pclk_en_q  <= pclk_en_d;
            ph_q       <= ph_d;
            pv_q       <= pv_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hblk_q     <= hblk_d;
            vblk_q     <= vblk_d;
            hsyn_q     <= hsyn_d;
            vsyn_q     <= vsyn_d;
            vblk_dly_q <= vblk_q;
            vb_stb_q   <= vb_stb_d;
        end
    end

    assign PCLK_EN = pclk_en_q;
    assign PH      = ph_q;
    assign PV      = pv_q;
    assign HBLK    = hblk_q;
    assign VBLK    = vblk_q;
    assign HSYN    = hsyn_q;
    assign VSYN    = vsyn_q;
    assign VB_STB  = vb_stb_q;

endmodule

// File: tb/tb_gaplus_hvgen.sv
// Bench for gaplus_hvgen using a reduced raster so several frames fit in a
// short run. A cycle-count reference model pushes the expected output vector
// at every MCLK rise; the checker pops and compares it on the falling edge.
module tb_gaplus_hvgen;

    localparam int CD    = 8;
    localparam int HT    = 32;
    localparam int HV    = 20;
    localparam int VT    = 24;
    localparam int VV    = 12;
    localparam int HS    = 22;
    localparam int HW    = 2;
    localparam int VS    = 14;
    localparam int VW    = 2;
    localparam int FRAME = CD * HT * VT;

    logic       MCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] HOFS = 4'd0;
    logic [3:0] VOFS = 4'd0;
    logic       PCLK_EN;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLK, VBLK, HSYN, VSYN, VB_STB;

    gaplus_hvgen #(
        .CLKDIV(CD), .HTOTAL(HT), .HVIS(HV), .VTOTAL(VT), .VVIS(VV),
        .HS_START(HS), .HS_WIDTH(HW), .VS_START(VS), .VS_WIDTH(VW)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .HOFS(HOFS), .VOFS(VOFS),
        .PCLK_EN(PCLK_EN), .PH(PH), .PV(PV), .HBLK(HBLK), .VBLK(VBLK),
        .HSYN(HSYN), .VSYN(VSYN), .VB_STB(VB_STB)
    );

    initial forever #5 MCLK = ~MCLK;

    logic [23:0] outs;
    assign outs = {PCLK_EN, PH, PV, HBLK, VBLK, HSYN, VSYN, VB_STB};

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] model(input int n, input int hh, input int vv);
        int div, p, ph, pv;
        logic [8:0] ph9, pv9;
        logic pe, hb, vb, hsy, vsy, stb;
        div = n % CD;
        p   = n / CD;
        ph  = p % HT;
        pv  = (p / HT) % VT;
        ph9 = ph[8:0];
        pv9 = pv[8:0];
        pe  = (div == CD - 1);
        hb  = (ph >= HV);
        vb  = (pv >= VV);
        hsy = (ph >= HS + hh) && (ph <= HS + hh + HW - 1);
        vsy = (pv >= VS + vv) && (pv <= VS + vv + VW - 1);
        stb = (pv == VV) && (ph == 0) && (div == 1);
        return {pe, ph9, pv9, hb, vb, hsy, vsy, stb};
    endfunction

    // Reference model: n_m counts MCLK edges since reset release.
    int n_m = 0;
    int hh_m = 0;
    int vv_m = 0;
    initial forever begin
        @(posedge MCLK);
        if (!RESET_N) begin
            n_m  = 0;
            hh_m = 0;
            vv_m = 0;
            exp_q.push_back(24'h0);
        end else begin
            n_m++;
            if (n_m % FRAME == 0) begin
                hh_m = int'($signed(HOFS));
                vv_m = int'($signed(VOFS));
            end
            exp_q.push_back(model(n_m, hh_m, vv_m));
        end
    end

    initial forever begin
        @(negedge MCLK);
        if (exp_q.size() > 0) check("outs", 32'(outs), 32'(exp_q.pop_front()));
    end

    // Sync edge positions and frame strobe count.
    int vb_cnt = 0;
    int hs_rise = -1, hs_fall = -1, vs_rise = -1, vs_fall = -1;
    logic hs_p = 1'b0, vs_p = 1'b0;
    initial forever begin
        @(negedge MCLK);
        if (VB_STB) vb_cnt++;
        if (HSYN && !hs_p) hs_rise = int'(PH);
        if (!HSYN && hs_p) hs_fall = int'(PH);
        if (VSYN && !vs_p) vs_rise = int'(PV);
        if (!VSYN && vs_p) vs_fall = int'(PV);
        hs_p = HSYN;
        vs_p = VSYN;
    end

    int k = 0;
    int vb0 = 0;

    task automatic step(input int m);
        repeat (m) @(negedge MCLK);
        #2;
        k += m;
    endtask

    initial begin
        step(3);
        check("rst_state", 32'(outs), 32'h0);
        RESET_N = 1'b1;
        k = 0;
        vb0 = vb_cnt;

        step(7);
        check("first_pclk", 32'(PCLK_EN), 32'd1);
        check("ph_at_7", 32'(PH), 32'd0);
        step(1);
        check("ph_first", 32'(PH), 32'd1);
        check("pclk_low", 32'(PCLK_EN), 32'd0);

        step(FRAME - 1 - k);
        check("pre_wrap_ph", 32'(PH), 32'(HT - 1));
        check("pre_wrap_pv", 32'(PV), 32'(VT - 1));
        step(1);
        check("wrap_phpv", 32'({PH, PV}), 32'd0);

        step(FRAME / 2);
        HOFS = 4'b1000;
        VOFS = 4'd7;

        step(2 * FRAME - CD - k);
        check("hs_rise_f1", 32'(hs_rise), 32'(HS));
        check("hs_fall_f1", 32'(hs_fall), 32'(HS + HW));
        check("vs_rise_f1", 32'(vs_rise), 32'(VS));
        check("vs_fall_f1", 32'(vs_fall), 32'(VS + VW));

        step(3 * FRAME - CD - k);
        check("hs_rise_f2", 32'(hs_rise), 32'(HS - 8));
        check("hs_fall_f2", 32'(hs_fall), 32'(HS - 8 + HW));
        check("vs_rise_f2", 32'(vs_rise), 32'(VS + 7));
        check("vs_fall_f2", 32'(vs_fall), 32'(VS + 7 + VW));

        step(3 * FRAME - k);
        check("vb_count", 32'(vb_cnt - vb0), 32'd3);

        step(3 * FRAME + (10 * HT + 20) * CD - k);
        check("pre_rst_ph", 32'(PH), 32'd20);
        check("pre_rst_pv", 32'(PV), 32'd10);
        RESET_N = 1'b0;
        #1;
        check("rst_async", 32'(outs), 32'h0);
        step(3);
        check("rst_hold", 32'(outs), 32'h0);
        RESET_N = 1'b1;
        k = 0;
        vb0 = vb_cnt;

        step(7);
        check("first_pclk2", 32'(PCLK_EN), 32'd1);
        step(1);
        check("ph_first2", 32'(PH), 32'd1);

        step(FRAME - CD - k);
        check("hs_rise_r0", 32'(hs_rise), 32'(HS));
        check("vs_rise_r0", 32'(vs_rise), 32'(VS));

        step(2 * FRAME - CD - k);
        check("hs_rise_r1", 32'(hs_rise), 32'(HS - 8));
        check("vs_rise_r1", 32'(vs_rise), 32'(VS + 7));
        check("vb_count2", 32'(vb_cnt - vb0), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
